// File: rtl/mixer_pkg.sv
// Shared definitions for the voice mixer: FSM states, default sample width,
// saturation limits and the accumulator-width helper.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACCUM = 2'd2,
        SAT   = 2'd3
    } mix_state_e;

    localparam int SAMPLE_W_DEF = 16;
    localparam int SAT_MAX      = (2 ** (SAMPLE_W_DEF - 1)) - 1;
    localparam int SAT_MIN      = -(2 ** (SAMPLE_W_DEF - 1));

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits (IN_W > OUT_W).
module sat_clamp #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAXV)
            dout = MAXV[OUT_W-1:0];
        else if (din < MINV)
            dout = MINV[OUT_W-1:0];
    end

endmodule

// File: rtl/voice_mixer.sv
// Sequential voice mixer: captures NUM_VOICES samples per frame, sums one per
// cycle, shifts, clamps and holds the result on sig. Optional MIX_SOFT_MUTE_EN
// replaces the hard mute with a 16-step gain fade.
module voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int GAIN_SHIFT = 2,
    parameter int UCNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_tick,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
    input  logic                           voice_valid,
    output logic                           voice_ready,
    input  logic                           mute,
    input  logic                           clr_status,
    output logic signed [SAMPLE_W-1:0]     sig,
    output logic                           busy,
    output logic                           overrun,
    output logic [UCNT_W-1:0]              underrun_cnt
);

    localparam int IDX_W = clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + IDX_W;

    mix_state_e                 state_q;
    logic                       voice_ready_q, busy_q, overrun_q;
    logic [UCNT_W-1:0]          ucnt_q;
    logic signed [SAMPLE_W-1:0] sig_q;
    logic signed [ACC_W-1:0]    acc_q, acc_d, shifted;
    logic [IDX_W-1:0]           idx_q;
    logic signed [SAMPLE_W-1:0] bank_q [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] cur_voice, clamped, mix_d;

    assign cur_voice = bank_q[idx_q];
    assign acc_d     = acc_q + {{(ACC_W-SAMPLE_W){cur_voice[SAMPLE_W-1]}}, cur_voice};
    assign shifted   = acc_q >>> GAIN_SHIFT;

    sat_clamp #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sum_clamp (
        .din  (shifted),
        .dout (clamped)
    );

`ifdef MIX_SOFT_MUTE_EN
    logic [4:0]                   g_q, g_d;
    logic signed [SAMPLE_W+4:0]   clamped_x, g_x, prod, prod_sh;
    logic signed [SAMPLE_W-1:0]   faded;

    always_comb begin
        g_d = g_q;
        if (mute) begin
            if (g_q != 5'd0) g_d = g_q - 5'd1;
        end else if (g_q != 5'd16) begin
            g_d = g_q + 5'd1;
        end
    end

    // The stepped gain is applied in the same SAT cycle, so the first muted frame is already at 15/16.
    assign clamped_x = {{5{clamped[SAMPLE_W-1]}}, clamped};
    assign g_x       = {{SAMPLE_W{1'b0}}, g_d};
    assign prod      = clamped_x * g_x;
    assign prod_sh   = prod >>> 4;

    sat_clamp #(.IN_W(SAMPLE_W+5), .OUT_W(SAMPLE_W)) u_fade_clamp (
        .din  (prod_sh),
        .dout (faded)
    );

    assign mix_d = faded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            g_q <= 5'd16;
        else if (state_q == SAT)
            g_q <= g_d;
    end
`else
    assign mix_d = mute ? '0 : clamped;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            voice_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            ucnt_q        <= '0;
            sig_q         <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            for (int i = 0; i < NUM_VOICES; i++) bank_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q       <= WAIT;
                        voice_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (voice_valid && voice_ready_q) begin
                        for (int i = 0; i < NUM_VOICES; i++)
                            bank_q[i] <= voice_data[i*SAMPLE_W +: SAMPLE_W];
                        acc_q         <= '0;
                        idx_q         <= '0;
                        voice_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ACCUM;
                        if (frame_tick) overrun_q <= 1'b1;
                    end else if (frame_tick && ucnt_q != '1) begin
                        ucnt_q <= ucnt_q + UCNT_W'(1);
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_VOICES - 1)) state_q <= SAT;
                    if (frame_tick) overrun_q <= 1'b1;
                end
                SAT: begin
                    sig_q   <= mix_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (frame_tick) overrun_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (clr_status) begin
                overrun_q <= 1'b0;
                ucnt_q    <= '0;
            end
        end
    end

    assign voice_ready  = voice_ready_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign underrun_cnt = ucnt_q;
    assign sig          = sig_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: two instances (GAIN_SHIFT 0 and 2) share stimulus.
module tb_voice_mixer;
    import mixer_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n, frame_tick, voice_valid, mute, clr_status;
    logic [63:0]        voice_data;
    logic               rdy0, rdy2, busy0, busy2, ovr0, ovr2;
    logic signed [15:0] sig0, sig2;
    logic [7:0]         ucnt0, ucnt2;
    int                 total = 0;
    int                 bad   = 0;

    always #5 clk = ~clk;

    voice_mixer #(.NUM_VOICES(4), .SAMPLE_W(16), .GAIN_SHIFT(0), .UCNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .voice_data(voice_data),
        .voice_valid(voice_valid), .voice_ready(rdy0), .mute(mute), .clr_status(clr_status),
        .sig(sig0), .busy(busy0), .overrun(ovr0), .underrun_cnt(ucnt0));

    voice_mixer #(.NUM_VOICES(4), .SAMPLE_W(16), .GAIN_SHIFT(2), .UCNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .voice_data(voice_data),
        .voice_valid(voice_valid), .voice_ready(rdy2), .mute(mute), .clr_status(clr_status),
        .sig(sig2), .busy(busy2), .overrun(ovr2), .underrun_cnt(ucnt2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_voices(input int a, input int b, input int c, input int d);
        voice_data = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    task automatic run_frame(input int a, input int b, input int c, input int d);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        set_voices(a, b, c, d);
        voice_valid = 1'b1;
        tick();
        voice_valid = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_tick = 0; voice_valid = 0; mute = 0; clr_status = 0; voice_data = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (int'(sig0) !== 0 || busy0 !== 1'b0 || rdy0 !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: sig=%0d busy=%b ready=%b required 0/0/0", sig0, busy0, rdy0);
        end
        total++;
        if (ovr0 !== 1'b0 || ucnt0 !== 8'd0) begin
            bad++; $display("FAIL reset_status: overrun=%b ucnt=%0d required 0/0", ovr0, ucnt0);
        end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_mix();
        int busy_n;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        total++;
        if (rdy0 !== 1'b1) begin
            bad++; $display("FAIL basic_ready_wait: ready=%b required 1", rdy0);
        end
        set_voices(1000, 2000, 3000, 4000);
        voice_valid = 1'b1;
        tick();
        voice_valid = 1'b0;
        total++;
        if (rdy0 !== 1'b0) begin
            bad++; $display("FAIL basic_ready_after_capture: ready=%b required 0", rdy0);
        end
        busy_n = (busy0 === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (busy0 === 1'b1) busy_n++;
        end
        total++;
        if (int'(sig0) !== 0) begin
            bad++; $display("FAIL basic_early_sig: sig=%0d at capture+4 required 0", sig0);
        end
        tick();
        total++;
        if (busy_n !== 5 || busy0 !== 1'b0) begin
            bad++; $display("FAIL basic_busy: busy cycles=%0d final=%b required 5/0", busy_n, busy0);
        end
        total++;
        if (int'(sig0) !== 10000) begin
            bad++; $display("FAIL basic_sum: sig=%0d required 10000", sig0);
        end
        total++;
        if (int'(sig2) !== 2500) begin
            bad++; $display("FAIL basic_sum_shift2: sig=%0d required 2500", sig2);
        end
    endtask

    task automatic test_saturation();
        run_frame(30000, 30000, 30000, 30000);
        total++;
        if (int'(sig0) !== SAT_MAX) begin
            bad++; $display("FAIL sat_pos: sig=%0d required %0d", sig0, SAT_MAX);
        end
        total++;
        if (int'(sig2) !== 30000) begin
            bad++; $display("FAIL sat_pos_shift2: sig=%0d required 30000", sig2);
        end
        run_frame(-30000, -30000, -30000, -30000);
        total++;
        if (int'(sig0) !== SAT_MIN) begin
            bad++; $display("FAIL sat_neg: sig=%0d required %0d", sig0, SAT_MIN);
        end
        total++;
        if (int'(sig2) !== -30000) begin
            bad++; $display("FAIL sat_neg_shift2: sig=%0d required -30000", sig2);
        end
        run_frame(32767, 32767, -32768, -32768);
        total++;
        if (int'(sig0) !== -2 || int'(sig2) !== -1) begin
            bad++; $display("FAIL sat_mixed: sig0=%0d sig2=%0d required -2/-1", sig0, sig2);
        end
    endtask

    task automatic test_gain_shift();
        run_frame(-4, -4, -4, -4);
        total++;
        if (int'(sig2) !== -4) begin
            bad++; $display("FAIL gain_shift2: sig=%0d required -4", sig2);
        end
        total++;
        if (int'(sig0) !== -16) begin
            bad++; $display("FAIL gain_shift0: sig=%0d required -16", sig0);
        end
    endtask

    task automatic test_underrun_overrun();
        frame_tick = 1'b1;
        tick();
        tick();
        frame_tick = 1'b0;
        total++;
        if (ucnt0 !== 8'd1 || int'(sig0) !== -16 || rdy0 !== 1'b1) begin
            bad++; $display("FAIL underrun_one: ucnt=%0d sig=%0d ready=%b required 1/-16/1", ucnt0, sig0, rdy0);
        end
        set_voices(1, 2, 3, 4);
        voice_valid = 1'b1;
        tick();
        voice_valid = 1'b0;
        tick();
        tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        total++;
        if (ovr0 !== 1'b1) begin
            bad++; $display("FAIL overrun_accum: overrun=%b required 1", ovr0);
        end
        tick();
        tick();
        total++;
        if (int'(sig0) !== 10 || busy0 !== 1'b0) begin
            bad++; $display("FAIL overrun_mix_completes: sig=%0d busy=%b required 10/0", sig0, busy0);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total++;
        if (ovr0 !== 1'b0 || ucnt0 !== 8'd0) begin
            bad++; $display("FAIL clr_status: overrun=%b ucnt=%0d required 0/0", ovr0, ucnt0);
        end
        frame_tick = 1'b1;
        tick();
        set_voices(5, 5, 5, 5);
        voice_valid = 1'b1;
        tick();
        frame_tick = 1'b0;
        voice_valid = 1'b0;
        total++;
        if (ovr0 !== 1'b1 || ucnt0 !== 8'd0) begin
            bad++; $display("FAIL overrun_at_capture: overrun=%b ucnt=%0d required 1/0", ovr0, ucnt0);
        end
        repeat (5) tick();
        total++;
        if (int'(sig0) !== 20) begin
            bad++; $display("FAIL capture_tick_mix: sig=%0d required 20", sig0);
        end
        clr_status = 1'b1;
        frame_tick = 1'b1;
        tick();
        clr_status = 1'b0;
        frame_tick = 1'b0;
        tick();
        for (int k = 0; k < 300; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
        total++;
        if (ucnt0 !== 8'd255 || int'(sig0) !== 20) begin
            bad++; $display("FAIL underrun_saturate: ucnt=%0d sig=%0d required 255/20", ucnt0, sig0);
        end
        clr_status = 1'b1;
        frame_tick = 1'b1;
        tick();
        clr_status = 1'b0;
        frame_tick = 1'b0;
        total++;
        if (ucnt0 !== 8'd0) begin
            bad++; $display("FAIL clr_priority: ucnt=%0d required 0", ucnt0);
        end
        set_voices(1, 2, 3, 4);
        voice_valid = 1'b1;
        tick();
        voice_valid = 1'b0;
        repeat (5) tick();
        total++;
        if (int'(sig0) !== 10) begin
            bad++; $display("FAIL post_underrun_mix: sig=%0d required 10", sig0);
        end
    endtask

    task automatic test_reset_mid_accum();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        set_voices(100, 100, 100, 100);
        voice_valid = 1'b1;
        tick();
        voice_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (int'(sig0) !== 0 || busy0 !== 1'b0 || rdy0 !== 1'b0) begin
            bad++; $display("FAIL async_reset: sig=%0d busy=%b ready=%b required 0/0/0", sig0, busy0, rdy0);
        end
        #2 rst_n = 1'b1;
        tick();
        run_frame(1000, 2000, 3000, 4000);
        total++;
        if (int'(sig0) !== 10000 || int'(sig2) !== 2500) begin
            bad++; $display("FAIL after_reset_mix: sig0=%0d sig2=%0d required 10000/2500", sig0, sig2);
        end
    endtask

    task automatic test_mute();
`ifdef MIX_SOFT_MUTE_EN
        mute = 1'b1;
        run_frame(64000 / 4, 16000, 16000, 16000);
        total++;
        if (int'(sig2) !== 15000) begin
            bad++; $display("FAIL soft_mute_first: sig=%0d required 15000", sig2);
        end
        for (int k = 0; k < 15; k++) run_frame(16000, 16000, 16000, 16000);
        total++;
        if (int'(sig2) !== 0) begin
            bad++; $display("FAIL soft_mute_silent: sig=%0d required 0", sig2);
        end
        mute = 1'b0;
        run_frame(16000, 16000, 16000, 16000);
        total++;
        if (int'(sig2) !== 1000) begin
            bad++; $display("FAIL soft_unmute_first: sig=%0d required 1000", sig2);
        end
        for (int k = 0; k < 15; k++) run_frame(16000, 16000, 16000, 16000);
        total++;
        if (int'(sig2) !== 16000) begin
            bad++; $display("FAIL soft_unmute_full: sig=%0d required 16000", sig2);
        end
`else
        mute = 1'b1;
        run_frame(1000, 2000, 3000, 4000);
        total++;
        if (int'(sig0) !== 0 || int'(sig2) !== 0) begin
            bad++; $display("FAIL hard_mute: sig0=%0d sig2=%0d required 0/0", sig0, sig2);
        end
        mute = 1'b0;
        run_frame(1000, 2000, 3000, 4000);
        total++;
        if (int'(sig0) !== 10000 || int'(sig2) !== 2500) begin
            bad++; $display("FAIL unmute: sig0=%0d sig2=%0d required 10000/2500", sig0, sig2);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_mix();
        test_saturation();
        test_gain_shift();
        test_underrun_overrun();
        test_reset_mid_accum();
        test_mute();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
